dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder: the slave end of the load/store interface driven by the pipeline's execute/memory stage.
- Accepts one request at a time over a valid/ready handshake, inserts programmable wait states, and performs RV32I byte/half/word stores and loads.
- Loads are sign- or zero-extended; each response is returned over a second valid/ready handshake.
- Replaces the single-cycle data memory so the core can be exercised against variable memory latency.

Parameters:
- ADDR_W, 10: word-address width; memory holds 2**ADDR_W 32-bit words.
- WAIT_CYCLES, 1: wait states between request acceptance and memory access (0..15).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- req_funct3  input  3  RV32I funct3 of the load/store.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  misaligned, out-of-range or illegal-funct3 request.

Behaviour:
- FSM states: IDLE, WAIT, RESP.
- Reset (rst=0, asynchronous): state=IDLE, wait counter=0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0. Memory contents are not reset.
- Reset mid-transaction aborts the transaction. A store whose access edge has not yet occurred is never written.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid=1, capture we/addr/wdata/funct3 and compute the error flag.
  - If WAIT_CYCLES=0, the memory access happens on this same edge and the FSM goes to RESP; otherwise load counter=WAIT_CYCLES and go to WAIT.
- WAIT:
  - req_ready=0; counter decrements each edge.
  - On the edge where counter==1, perform the access and go to RESP.
  - Latency: rsp_valid first high in the cycle after acceptance edge + WAIT_CYCLES.
- Access rules:
  - Word index = addr[ADDR_W+1:2].
  - Error when any of the following holds; an erroneous request performs no write and returns rdata=0, err=1:
    - addr[31:ADDR_W+2] != 0;
    - half access with addr[0]=1;
    - word access with addr[1:0] != 0;
    - funct3 not in the legal set.
  - Legal load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Legal store funct3: 000 SB, 001 SH, 010 SW.
  - Stores write only the addressed bytes: SB lane = addr[1:0]; SH lanes = addr[1]. Other bytes are unchanged.
  - Loads select the lane the same way. LB/LH sign-extend; LBU/LHU zero-extend.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err held stable while rsp_ready=0.
  - On an edge with rsp_ready=1: rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE.
  - req_ready stays 0 in RESP, so back-to-back throughput is at best one request per WAIT_CYCLES+2 cycles.
- Only one transaction is outstanding, so read-after-write is always coherent.
- req_* inputs are ignored outside the IDLE acceptance edge.

Optional Feature:
- DMEM_STORE_ACK_EN defined: every request, load or store, produces exactly one RESP handshake.
- DMEM_STORE_ACK_EN undefined: stores are posted.
  - After the access edge the FSM returns directly from the access edge to IDLE with rsp_valid never asserted.
  - Erroneous stores are silently dropped.
  - Loads behave identically in both builds.

Test Plan:
- WAIT_CYCLES=1, ack enabled: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_valid 2 cycles after each acceptance; load rsp_rdata=0xDEADBEEF, err=0.
- Extension: after the SW above, LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
- Partial store: SB 0x11 data 0x55 over 0xDEADBEEF, then LW 0x10 -> 0xDEAD55EF.
- Errors:
  - LW 0x12 -> rsp_err=1, rdata=0.
  - SH 0x11 data 0x1234 -> err=1, and a following LW 0x10 is unchanged.
  - LW 0x00001000 with ADDR_W=10 -> err=1.
  - funct3=011 -> err=1.
- Backpressure: hold rsp_ready=0 for 5 cycles during a load -> rsp_valid, rdata and err stable and req_ready=0 throughout; a req_valid pulse during that window is not accepted.
- Reset in WAIT: pull rst low one cycle after accepting SW 0x20 data 0x1 with WAIT_CYCLES=3 -> outputs at reset values immediately; a later LW 0x20 returns the prior contents.
- Build without DMEM_STORE_ACK_EN: SW 0x8 -> rsp_valid stays 0 and req_ready returns to 1 after WAIT_CYCLES+1 cycles; LW 0x8 returns the stored value.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Request/response channels between the pipeline's memory stage (master)
// and the data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding RV32I load/store with WAIT_CYCLES wait states.
// Optional macro DMEM_STORE_ACK_EN: stores also return a response (default: stores are posted).
module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int         WORDS     = 2 ** ADDR_W;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
`ifdef DMEM_STORE_ACK_EN
  localparam bit STORE_ACK = 1'b1;
`else
  localparam bit STORE_ACK = 1'b0;
`endif

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              we_q;
  logic [31:0]       addr_q, wdata_q;
  logic [2:0]        funct3_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic              accept, access, respond, legal;
  logic              acc_we, acc_err;
  logic [31:0]       acc_addr, acc_wdata, acc_word;
  logic [2:0]        acc_funct3;
  logic [ADDR_W-1:0] acc_idx;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_data, store_data;
  logic [3:0]        store_be;

  logic [31:0]       mem [WORDS];

  // With zero wait states the access happens on the acceptance edge, so it
  // must use the live request rather than the captured copy.
  assign acc_we     = (state == IDLE) ? bus.req_we     : we_q;
  assign acc_addr   = (state == IDLE) ? bus.req_addr   : addr_q;
  assign acc_wdata  = (state == IDLE) ? bus.req_wdata  : wdata_q;
  assign acc_funct3 = (state == IDLE) ? bus.req_funct3 : funct3_q;

  assign accept  = (state == IDLE) && bus.req_valid;
  assign access  = rst && (((WAIT_CYCLES == 0) && accept) ||
                           ((state == WAIT) && (cnt == 4'd1)));
  assign respond = STORE_ACK || !acc_we;

  assign legal   = acc_we ? (acc_funct3 inside {3'b000, 3'b001, 3'b010})
                          : (acc_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign acc_err = !legal
                || ((acc_addr >> (ADDR_W + 2)) != 32'd0)
                || ((acc_funct3[1:0] == 2'b01) && acc_addr[0])
                || ((acc_funct3[1:0] == 2'b10) && (acc_addr[1:0] != 2'b00));

  assign acc_idx  = acc_addr[ADDR_W+1:2];
  assign acc_word = mem[acc_idx];

  always_comb begin
    case (acc_addr[1:0])
      2'b00:   byte_sel = acc_word[7:0];
      2'b01:   byte_sel = acc_word[15:8];
      2'b10:   byte_sel = acc_word[23:16];
      default: byte_sel = acc_word[31:24];
    endcase
    half_sel = acc_addr[1] ? acc_word[31:16] : acc_word[15:0];
    case (acc_funct3)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_data = {24'd0, byte_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = acc_word;
    endcase
  end

  // Store data is replicated across lanes; the byte enables pick the addressed ones.
  always_comb begin
    store_be   = 4'b1111;
    store_data = acc_wdata;
    case (acc_funct3[1:0])
      2'b00: begin
        store_be   = 4'b0001 << acc_addr[1:0];
        store_data = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        store_be   = acc_addr[1] ? 4'b1100 : 4'b0011;
        store_data = {2{acc_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = respond ? RESP : IDLE;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = respond ? RESP : IDLE;
      end
      RESP: begin
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      funct3_q <= 3'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        we_q     <= bus.req_we;
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        funct3_q <= bus.req_funct3;
      end
      if (access && respond) begin
        err_q   <= acc_err;
        rdata_q <= (acc_err || acc_we) ? 32'd0 : load_data;
      end else if ((state == RESP) && bus.rsp_ready) begin
        err_q   <= 1'b0;
        rdata_q <= 32'd0;
      end
    end
  end

  // NOTE: the storage array is deliberately left out of reset; only the
  // control path is reset, and an aborted store never reaches this block.
  always_ff @(posedge clk) begin
    if (access && acc_we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (store_be[i]) mem[acc_idx][8*i +: 8] <= store_data[8*i +: 8];
      end
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a transaction-timeline model checked every cycle,
// directed RV32I cases, random traffic, and a second instance for reset-in-WAIT.
module tb_dmem_responder;

  localparam int AW = 10;
  localparam int W  = 1;
  localparam int W3 = 3;
`ifdef DMEM_STORE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic rst3 = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if bus ();
  dmem_responder_if b3 ();

  dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(W))  dut  (.clk(clk), .rst(rst),  .bus(bus));
  dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(W3)) dut3 (.clk(clk), .rst(rst3), .bus(b3));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [2**AW];
  bit          m_busy, m_resp, m_err;
  logic [31:0] m_rdata;
  int          cyc, m_due;
  bit          m_we;
  logic [31:0] m_addr, m_wdata;
  logic [2:0]  m_f3;
  bit          cmp_on = 1'b0;

  function automatic bit m_bad(input bit we, input logic [31:0] a, input logic [2:0] f3);
    bit lg;
    case (f3)
      3'b000, 3'b001, 3'b010: lg = 1'b1;
      3'b100, 3'b101:         lg = !we;
      default:                lg = 1'b0;
    endcase
    return !lg || ((a >> (AW + 2)) != 0) || (f3[1:0] == 2'b01 && a[0])
               || (f3[1:0] == 2'b10 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] word, input logic [31:0] a,
                                         input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*a[1:0] +: 8];
    h = word[16*a[1] +: 16];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return word;
    endcase
  endfunction

  task m_access();
    bit          e;
    int          idx;
    e   = m_bad(m_we, m_addr, m_f3);
    idx = int'(m_addr[AW+1:2]);
    m_busy = 1'b0;
    if (!e && m_we) begin
      case (m_f3[1:0])
        2'b00:   m_mem[idx][8*m_addr[1:0] +: 8] = m_wdata[7:0];
        2'b01:   m_mem[idx][16*m_addr[1] +: 16] = m_wdata[15:0];
        default: m_mem[idx] = m_wdata;
      endcase
    end
    if (ACK || !m_we) begin
      m_resp  = 1'b1;
      m_err   = e;
      m_rdata = (e || m_we) ? 32'd0 : m_load(m_mem[idx], m_addr, m_f3);
    end
  endtask

  // Access is due WAIT edges after acceptance; only one transaction at a time.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 1'b0; m_resp = 1'b0; m_err = 1'b0; m_rdata = 32'd0;
    end else begin
      if (m_resp) begin
        if (bus.rsp_ready) begin m_resp = 1'b0; m_err = 1'b0; m_rdata = 32'd0; end
      end else if (m_busy) begin
        if (cyc == m_due) m_access();
      end else if (bus.req_valid) begin
        m_we = bus.req_we; m_addr = bus.req_addr; m_wdata = bus.req_wdata; m_f3 = bus.req_funct3;
        m_busy = 1'b1;
        m_due  = cyc + W;
        if (W == 0) m_access();
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("req_ready", 32'(bus.req_ready), 32'(!(m_busy || m_resp)));
      check("rsp_valid", 32'(bus.rsp_valid), 32'(m_resp));
      check("rsp_rdata", bus.rsp_rdata, m_rdata);
      check("rsp_err",   32'(bus.rsp_err), 32'(m_err));
    end
  end

  // ---------------- drivers ----------------
  task automatic xact(input bit we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [2:0] f3, input int hold,
                      output logic [31:0] rd, output logic er, output int lat);
    int n;
    rd = 32'd0; er = 1'b0;
    @(negedge clk);
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("accept_wait", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a;
    bus.req_wdata = wd;   bus.req_funct3 = f3;
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    bus.req_funct3 = 3'($urandom);
    lat = 0;
    while (!((ACK || !we) ? bus.rsp_valid : bus.req_ready) && lat < 60) begin
      @(negedge clk); lat++;
    end
    check("done_wait", 32'((ACK || !we) ? bus.rsp_valid : bus.req_ready), 32'd1);
    if (ACK || !we) begin
      for (int i = 0; i < hold; i++) begin
        bus.req_valid = (i == 1); bus.req_we = 1'b1; bus.req_addr = 32'h10;
        bus.req_wdata = 32'h0BAD0BAD; bus.req_funct3 = 3'b010;
        @(negedge clk);
      end
      bus.req_valid = 1'b0;
      rd = bus.rsp_rdata;
      er = bus.rsp_err;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
    end
  endtask

  task automatic x3(input bit we, input logic [31:0] a, input logic [31:0] wd,
                    input logic [2:0] f3, output logic [31:0] rd, output int lat);
    int n;
    @(negedge clk);
    b3.req_valid = 1'b1; b3.req_we = we; b3.req_addr = a; b3.req_wdata = wd; b3.req_funct3 = f3;
    @(negedge clk);
    b3.req_valid = 1'b0;
    lat = 0;
    while (!(b3.rsp_valid || (we && !ACK && b3.req_ready)) && lat < 60) begin
      @(negedge clk); lat++;
    end
    rd = b3.rsp_rdata;
    n = 0;
    while (!b3.req_ready && n < 10) begin @(negedge clk); n++; end
    check("x3_idle", 32'(b3.req_ready), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [2:0]  legal_f3 [5];
    legal_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 32'd0;
    bus.req_wdata = 32'd0; bus.req_funct3 = 3'd0; bus.rsp_ready = 1'b0;
    b3.req_valid = 1'b0; b3.req_we = 1'b0; b3.req_addr = 32'd0;
    b3.req_wdata = 32'd0; b3.req_funct3 = 3'd0; b3.rsp_ready = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_rsp_err",   32'(bus.rsp_err), 32'd0);
    @(negedge clk);
    rst = 1'b1; rst3 = 1'b1; cmp_on = 1'b1;

    // Word store then loads of every width
    xact(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 0, rd, er, lat);
    check("sw_lat", 32'(lat), 32'(W));
    check("sw_err", 32'(er), 32'd0);
    xact(1'b0, 32'h10, 32'd0, 3'b010, 0, rd, er, lat);
    check("lw_data", rd, 32'hDEADBEEF);
    check("lw_err", 32'(er), 32'd0);
    check("lw_lat", 32'(lat), 32'(W));
    xact(1'b0, 32'h13, 32'd0, 3'b000, 0, rd, er, lat); check("lb_13",  rd, 32'hFFFFFFDE);
    xact(1'b0, 32'h13, 32'd0, 3'b100, 0, rd, er, lat); check("lbu_13", rd, 32'h000000DE);
    xact(1'b0, 32'h12, 32'd0, 3'b001, 0, rd, er, lat); check("lh_12",  rd, 32'hFFFFDEAD);
    xact(1'b0, 32'h10, 32'd0, 3'b101, 0, rd, er, lat); check("lhu_10", rd, 32'h0000BEEF);

    // Partial store
    xact(1'b1, 32'h11, 32'h00000055, 3'b000, 0, rd, er, lat);
    xact(1'b0, 32'h10, 32'd0, 3'b010, 0, rd, er, lat); check("sb_merge", rd, 32'hDEAD55EF);

    // Error cases
    xact(1'b0, 32'h12, 32'd0, 3'b010, 0, rd, er, lat);
    check("lw_mis_err", 32'(er), 32'd1); check("lw_mis_data", rd, 32'd0);
    xact(1'b1, 32'h11, 32'h1234, 3'b001, 0, rd, er, lat);
    check("sh_mis_err", 32'(er), 32'(ACK));
    xact(1'b0, 32'h10, 32'd0, 3'b010, 0, rd, er, lat); check("sh_mis_nowrite", rd, 32'hDEAD55EF);
    xact(1'b0, 32'h00001000, 32'd0, 3'b010, 0, rd, er, lat); check("oor_err", 32'(er), 32'd1);
    xact(1'b0, 32'h10, 32'd0, 3'b011, 0, rd, er, lat);
    check("f3_err", 32'(er), 32'd1); check("f3_data", rd, 32'd0);

    // Backpressure with an ignored request pulse
    xact(1'b0, 32'h10, 32'd0, 3'b010, 5, rd, er, lat); check("bp_data", rd, 32'hDEAD55EF);
    xact(1'b0, 32'h10, 32'd0, 3'b010, 0, rd, er, lat); check("bp_no_accept", rd, 32'hDEAD55EF);

    // Pin the model against hand-computed values
    check("model_mem4", m_mem[4], 32'hDEAD55EF);
    check("model_lh", m_load(32'hDEADBEEF, 32'h12, 3'b001), 32'hFFFFDEAD);

    // Random traffic over an initialised window
    for (int i = 0; i < 16; i++) xact(1'b1, 32'(i * 4), $urandom, 3'b010, 0, rd, er, lat);
    for (int i = 0; i < 300; i++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : legal_f3[$urandom_range(0, 4)];
      a  = 32'($urandom_range(0, 63)) | (($urandom_range(0, 15) == 0) ? 32'h1000 : 32'h0);
      xact(1'($urandom_range(0, 1)), a, $urandom, f3, $urandom_range(0, 3), rd, er, lat);
    end

    // Second instance: latency and reset during WAIT
    x3(1'b1, 32'h20, 32'hA5A50001, 3'b010, rd, lat);
    check("w3_sw_lat", 32'(lat), 32'(W3));
    @(negedge clk);
    b3.req_valid = 1'b1; b3.req_we = 1'b1; b3.req_addr = 32'h20;
    b3.req_wdata = 32'h1; b3.req_funct3 = 3'b010;
    @(negedge clk);
    b3.req_valid = 1'b0;
    @(negedge clk);
    rst3 = 1'b0;
    #1;
    check("w3_rst_req_ready", 32'(b3.req_ready), 32'd1);
    check("w3_rst_rsp_valid", 32'(b3.rsp_valid), 32'd0);
    check("w3_rst_rsp_rdata", b3.rsp_rdata, 32'd0);
    check("w3_rst_rsp_err",   32'(b3.rsp_err), 32'd0);
    @(negedge clk);
    rst3 = 1'b1;
    x3(1'b0, 32'h20, 32'd0, 3'b010, rd, lat);
    check("w3_lw_prior", rd, 32'hA5A50001);
    check("w3_lw_lat", 32'(lat), 32'(W3));

    repeat (2) @(negedge clk);
    cmp_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
